mem_read_sequencer: RTL and testbench

Multicycle memory-access controller for the CPU datapath. It accepts one load/store request at a time from the main control unit and drives the 3-bit select of the 6-input memory-address mux. It sequences the fixed-latency memory through address, wait, optional read-modify-write and completion phases. It also performs byte/halfword extraction with sign/zero extension on loads and lane merging on sub-word stores.

---
 rtl/mem_read_sequencer_pkg.sv | 21 ++
 rtl/load_store_align.sv | 41 ++++
 rtl/mem_read_sequencer.sv | 159 +++++++++++++++
 tb/tb_mem_read_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_sequencer_pkg.sv
// Shared definitions for the multicycle memory-access sequencer:
// FSM state encoding, access-size codes, source limit and counter width.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [2:0] SRC_MAX = 3'd5;

    localparam int CNT_W = 3;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: extracts and extends a byte/halfword from a
// memory word for loads, and merges sub-word store data into a memory word.
module load_store_align
    import mem_seq_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] sdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Little-endian lane picks: byte by addr_lo, halfword by addr_lo[1].
    assign lane_b = word_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_h = word_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Extend the selected lane for loads; overwrite only the target lane for stores.
    always_comb begin
        load_o  = word_i;
        store_o = sdata_i;
        case (size_i)
            SZ_HALF: begin
                load_o  = {{16{signed_i & lane_h[15]}}, lane_h};
                store_o = word_i;
                store_o[{addr_lo_i[1], 4'b0000} +: 16] = sdata_i[15:0];
            end
            SZ_BYTE: begin
                load_o  = {{24{signed_i & lane_b[7]}}, lane_b};
                store_o = word_i;
                store_o[{addr_lo_i, 3'b000} +: 8] = sdata_i[7:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_read_sequencer.sv
// Multicycle load/store controller: drives the address-mux select, sequences
// a fixed-latency memory through address/wait/read-modify-write/done phases,
// and returns extended load data or merged sub-word store words.
module mem_read_sequencer
    import mem_seq_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  req_src,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  addr_sel,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               write_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic [31:0]        wdata_q;
    logic [1:0]         addr_lo_q;
    logic [2:0]         addr_sel_q;
    logic [31:0]        mem_wdata_q;
    logic [31:0]        load_data_q;

    logic               req_ok;
    logic               misaligned;
    logic [31:0]        load_ext;
    logic [31:0]        store_merged;

    assign req_ok     = (req_src <= SRC_MAX) && (req_size != 2'b11);
    assign misaligned = ((size_q == SZ_WORD) && (addr_lo != 2'b00)) ||
                        ((size_q == SZ_HALF) && addr_lo[0]);

    // The memory word arrives during WAIT while addr_lo_q is already held.
    load_store_align u_align (
        .word_i    (mem_rdata),
        .addr_lo_i (addr_lo_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .sdata_i   (wdata_q),
        .load_o    (load_ext),
        .store_o   (store_merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and strobe decode; the ADDR-phase write strobe is qualified by
    // the live low address bits so a misaligned word store never reaches memory.
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;
        mem_wr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) state_d = req_ok ? ST_ADDR : ST_DONE;
            end
            ST_ADDR: begin
                if (misaligned) begin
                    state_d = ST_DONE;
                end else if (write_q && (size_q == SZ_WORD)) begin
                    mem_wr  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = write_q ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                mem_wr  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches, latency counter, error flag and registered data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            err_q       <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= SZ_WORD;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            addr_lo_q   <= '0;
            addr_sel_q  <= '0;
            mem_wdata_q <= '0;
            load_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (req_ok) begin
                            write_q    <= req_write;
                            size_q     <= req_size;
                            signed_q   <= req_signed;
                            wdata_q    <= wdata;
                            addr_sel_q <= req_src;
                            if (req_write && (req_size == SZ_WORD)) mem_wdata_q <= wdata;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    addr_lo_q <= addr_lo;
                    cnt_q     <= CNT_INIT;
                    if (misaligned) err_q <= 1'b1;
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        if (write_q) mem_wdata_q <= store_merged;
                        else         load_data_q <= load_ext;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign addr_sel  = addr_sel_q;
    assign mem_wdata = mem_wdata_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Testbench for mem_read_sequencer: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_read_sequencer;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  req_src;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] wdata;
    logic [1:0]  addr_lo;
    logic [31:0] mem_rdata;
    logic [2:0]  addr_sel;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] load_data;
    logic        busy;
    logic        done;
    logic        err;

    int nvec = 0;
    int nerr = 0;

    // Reference state carried across transactions.
    logic [2:0]  sel_model = 3'd0;
    logic [31:0] ld_model  = 32'd0;

    always #5 clk = ~clk;

    mem_read_sequencer #(.MEM_LATENCY(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_src    (req_src),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .wdata      (wdata),
        .addr_lo    (addr_lo),
        .mem_rdata  (mem_rdata),
        .addr_sel   (addr_sel),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .load_data  (load_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction: raise req in an IDLE cycle, follow it to done and
    // compare latency, strobes, data and held outputs with the model.
    task automatic run_txn(input logic [2:0] src, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] wd, input logic [1:0] alo,
                           input logic [31:0] rd);
        int          exp_lat;
        logic        exp_err;
        int          exp_wr_cyc;
        logic [31:0] exp_wdata;
        logic [31:0] mask;
        logic [31:0] lane;
        int          sh;
        int          done_cyc;
        int          wr_cnt;
        int          wr_cyc;
        logic [31:0] wr_data;
        logic        got_err;
        logic        got_done;

        exp_err    = 1'b0;
        exp_wr_cyc = 0;
        exp_wdata  = 32'd0;
        if (src > 3'd5 || sz == 2'b11) begin
            exp_lat = 1;
            exp_err = 1'b1;
        end else begin
            sel_model = src;
            if ((sz == 2'b00 && alo != 2'b00) || (sz == 2'b01 && alo[0])) begin
                exp_lat = 2;
                exp_err = 1'b1;
            end else if (wr && sz == 2'b00) begin
                exp_lat    = 2;
                exp_wr_cyc = 1;
                exp_wdata  = wd;
            end else if (!wr) begin
                exp_lat = L + 2;
                if (sz == 2'b00) begin
                    ld_model = rd;
                end else if (sz == 2'b01) begin
                    lane = (rd >> (16 * int'(alo[1]))) & 32'h0000_FFFF;
                    if (sg && lane[15]) lane = lane | 32'hFFFF_0000;
                    ld_model = lane;
                end else begin
                    lane = (rd >> (8 * int'(alo))) & 32'h0000_00FF;
                    if (sg && lane[7]) lane = lane | 32'hFFFF_FF00;
                    ld_model = lane;
                end
            end else begin
                exp_lat    = L + 3;
                exp_wr_cyc = L + 2;
                sh   = (sz == 2'b01) ? 16 * int'(alo[1]) : 8 * int'(alo);
                mask = ((sz == 2'b01) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
                exp_wdata = (rd & ~mask) | ((wd << sh) & mask);
            end
        end

        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        req        = 1'b1;
        req_src    = src;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        wdata      = wd;
        addr_lo    = alo;
        mem_rdata  = $urandom;

        got_done = 1'b0;
        got_err  = 1'b0;
        done_cyc = 0;
        wr_cnt   = 0;
        wr_cyc   = 0;
        wr_data  = 32'd0;
        for (int c = 1; c <= 40 && !got_done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req     = 1'b0;
                req_src = 3'($urandom);
                wdata   = $urandom;
                chk("busy_c1", {31'd0, busy}, 32'd1);
                chk("addr_sel_c1", {29'd0, addr_sel}, {29'd0, sel_model});
            end
            if (mem_wr) begin
                wr_cnt++;
                wr_cyc  = c;
                wr_data = mem_wdata;
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = c;
                got_err  = err;
            end
            // Memory output is only meaningful L cycles after the address settles.
            mem_rdata = (c >= L) ? rd : $urandom;
        end

        chk("done_latency", done_cyc, exp_lat);
        chk("err", {31'd0, got_err}, {31'd0, exp_err});
        chk("wr_count", wr_cnt, (exp_wr_cyc != 0) ? 1 : 0);
        if (exp_wr_cyc != 0) begin
            chk("wr_cycle", wr_cyc, exp_wr_cyc);
            chk("mem_wdata", wr_data, exp_wdata);
        end
        chk("load_data", load_data, ld_model);
        chk("addr_sel_hold", {29'd0, addr_sel}, {29'd0, sel_model});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_addr_sel"}, {29'd0, addr_sel}, 32'd0);
        chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_load_data"}, load_data, 32'd0);
    endtask

    initial begin
        int wr_seen;
        reset      = 1'b1;
        req        = 1'b0;
        req_src    = 3'd0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        wdata      = 32'd0;
        addr_lo    = 2'b00;
        mem_rdata  = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b0;

        // Directed cases from the intended use.
        run_txn(3'd2, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 32'hDEADBEEF);
        run_txn(3'd1, 1'b0, 2'b10, 1'b1, 32'h0, 2'b11, 32'h80123456);
        run_txn(3'd1, 1'b0, 2'b01, 1'b0, 32'h0, 2'b10, 32'h80123456);
        run_txn(3'd3, 1'b1, 2'b10, 1'b0, 32'h000000AB, 2'b01, 32'h11223344);
        run_txn(3'd4, 1'b1, 2'b00, 1'b0, 32'hCAFEF00D, 2'b00, 32'h0);
        run_txn(3'd6, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0);
        run_txn(3'd0, 1'b0, 2'b01, 1'b1, 32'h0, 2'b01, 32'h12345678);
        run_txn(3'd5, 1'b0, 2'b11, 1'b0, 32'h0, 2'b00, 32'h0);
        run_txn(3'd5, 1'b1, 2'b01, 1'b0, 32'h0000BEEF, 2'b10, 32'hA5A5A5A5);

        // Reset in the WAIT phase of a byte store.
        @(negedge clk);
        req       = 1'b1;
        req_src   = 3'd3;
        req_write = 1'b1;
        req_size  = 2'b10;
        wdata     = 32'h000000AB;
        addr_lo   = 2'b01;
        mem_rdata = 32'h11223344;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        reset     = 1'b0;
        sel_model = 3'd0;
        ld_model  = 32'd0;
        wr_seen   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_wr) wr_seen++;
        end
        chk("midrst_no_wr", wr_seen, 0);
        run_txn(3'd2, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0BADF00D);

        // Randomized traffic, mostly legal.
        for (int n = 0; n < 60; n++) begin
            logic [2:0] s;
            logic [1:0] z;
            s = ($urandom_range(0, 7) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            z = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_txn(s, 1'($urandom), z, 1'($urandom), $urandom, 2'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
